m_btb_predictor: RTL and testbench

Parametrised branch target buffer and predictor, fully associative with N ways. Each entry holds a branch PC tag, a target PC and a saturating direction counter, with true-LRU replacement. The IF stage performs a combinational lookup on the fetch PC. The EX stage updates the entry at posedge with the resolved direction and target. Replaces the fixed 2-entry predictor and 2-entry target cache pair in the pipelined processor.

---
 rtl/m_btb_predictor.sv | 180 ++++++++++++++++++
 tb/tb_m_btb_predictor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/m_btb_predictor.sv
// Fully associative branch target buffer with saturating direction counters
// and true-LRU replacement. Lookup (IF) is combinational on w_paddr; the
// resolved-branch update (EX) is applied at posedge.
// Optional statistics counters are built only when BTB_STATS_EN is defined.
module m_btb_predictor #(
   parameter int ENTRIES = 4,
   parameter int ADDR_W  = 11,
   parameter int CNT_W   = 2
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic [ADDR_W-1:0] w_paddr,
   output logic              w_pre,
   output logic              w_pr,
   output logic [ADDR_W-1:0] w_ptgt,
   input  logic              w_be,
   input  logic [ADDR_W-1:0] w_baddr,
   input  logic              w_br,
   input  logic [ADDR_W-1:0] w_btgt,
   input  logic              w_flush,
   output logic [31:0]       w_stat_upd,
   output logic [31:0]       w_stat_mis
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   // Weakly taken = MSB set, rest clear; weakly not-taken = MSB clear, rest set.
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
   localparam logic [IDX_W-1:0] AGE_OLDEST = IDX_W'(ENTRIES - 1);

   logic              valid_q [ENTRIES];
   logic              valid_d [ENTRIES];
   logic [ADDR_W-1:0] tag_q   [ENTRIES];
   logic [ADDR_W-1:0] tag_d   [ENTRIES];
   logic [ADDR_W-1:0] tgt_q   [ENTRIES];
   logic [ADDR_W-1:0] tgt_d   [ENTRIES];
   logic [CNT_W-1:0]  cnt_q   [ENTRIES];
   logic [CNT_W-1:0]  cnt_d   [ENTRIES];
   logic [IDX_W-1:0]  age_q   [ENTRIES];
   logic [IDX_W-1:0]  age_d   [ENTRIES];

   logic              look_hit;
   logic [IDX_W-1:0]  look_idx;
   logic              upd_hit;
   logic [IDX_W-1:0]  hit_idx;
   logic              inv_found;
   logic [IDX_W-1:0]  inv_idx;
   logic [IDX_W-1:0]  lru_idx;
   logic [IDX_W-1:0]  sel_idx;

   // IF-side lookup: tags are unique among valid entries, so at most one hits.
   always_comb begin
      look_hit = 1'b0;
      look_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == w_paddr)) begin
            look_hit = 1'b1;
            look_idx = IDX_W'(i);
         end
      end
   end

   assign w_pre  = look_hit;
   assign w_pr   = look_hit & cnt_q[look_idx][CNT_W-1];
   assign w_ptgt = look_hit ? tgt_q[look_idx] : '0;

   // EX-side match, lowest-index invalid entry, and oldest entry by age.
   always_comb begin
      upd_hit   = 1'b0;
      hit_idx   = '0;
      inv_found = 1'b0;
      inv_idx   = '0;
      lru_idx   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == w_baddr)) begin
            upd_hit = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid_q[i] && !inv_found) begin
            inv_found = 1'b1;
            inv_idx   = IDX_W'(i);
         end
         if (age_q[i] == AGE_OLDEST) begin
            lru_idx = IDX_W'(i);
         end
      end
   end

   assign sel_idx = upd_hit ? hit_idx : (inv_found ? inv_idx : lru_idx);

   // Next-state of all entries: flush beats update; the touched entry becomes MRU.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_d[i] = valid_q[i];
         tag_d[i]   = tag_q[i];
         tgt_d[i]   = tgt_q[i];
         cnt_d[i]   = cnt_q[i];
         age_d[i]   = age_q[i];
      end
      if (w_flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i] = 1'b0;
         end
      end else if (w_be) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (IDX_W'(i) == sel_idx) begin
               age_d[i] = '0;
            end else if (age_q[i] < age_q[sel_idx]) begin
               age_d[i] = age_q[i] + IDX_W'(1);
            end
         end
         valid_d[sel_idx] = 1'b1;
         tag_d[sel_idx]   = w_baddr;
         if (upd_hit) begin
            if (w_br) begin
               tgt_d[sel_idx] = w_btgt;
               if (cnt_q[sel_idx] != CNT_MAX) begin
                  cnt_d[sel_idx] = cnt_q[sel_idx] + CNT_W'(1);
               end
            end else if (cnt_q[sel_idx] != '0) begin
               cnt_d[sel_idx] = cnt_q[sel_idx] - CNT_W'(1);
            end
         end else begin
            tgt_d[sel_idx] = w_btgt;
            cnt_d[sel_idx] = w_br ? CNT_WT : CNT_WNT;
         end
      end
   end

   // State register: reset clears valid bits and restores ages to their index.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            age_q[i]   <= IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= valid_d[i];
            tag_q[i]   <= tag_d[i];
            tgt_q[i]   <= tgt_d[i];
            cnt_q[i]   <= cnt_d[i];
            age_q[i]   <= age_d[i];
         end
      end
   end

`ifdef BTB_STATS_EN
   logic        upd_en;
   logic        mis_cond;
   logic [31:0] stat_upd_q;
   logic [31:0] stat_mis_q;

   assign upd_en   = w_be & ~w_flush;
   assign mis_cond = !upd_hit
                  || (cnt_q[hit_idx][CNT_W-1] != w_br)
                  || (w_br && (tgt_q[hit_idx] != w_btgt));

   // Accepted-update and misprediction counters, wrapping at 2^32.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         stat_upd_q <= '0;
         stat_mis_q <= '0;
      end else if (upd_en) begin
         stat_upd_q <= stat_upd_q + 32'd1;
         if (mis_cond) begin
            stat_mis_q <= stat_mis_q + 32'd1;
         end
      end
   end

   assign w_stat_upd = stat_upd_q;
   assign w_stat_mis = stat_mis_q;
`else
   assign w_stat_upd = '0;
   assign w_stat_mis = '0;
`endif

endmodule

// File: tb/tb_m_btb_predictor.sv
// Directed table-driven bench for m_btb_predictor (ENTRIES=4, ADDR_W=11, CNT_W=2).
module tb_m_btb_predictor;

   localparam int ADDR_W = 11;

`ifdef BTB_STATS_EN
   localparam int EXP_UPD = 3;
   localparam int EXP_MIS = 2;
`else
   localparam int EXP_UPD = 0;
   localparam int EXP_MIS = 0;
`endif

   typedef struct {
      logic              rst;
      logic              flush;
      logic              be;
      logic [ADDR_W-1:0] baddr;
      logic              br;
      logic [ADDR_W-1:0] btgt;
      logic [ADDR_W-1:0] paddr;
      logic              exp_pre;
      logic              exp_pr;
      logic [ADDR_W-1:0] exp_ptgt;
      string             name;
   } vec_t;

   logic              w_clk = 1'b0;
   logic              w_rst;
   logic [ADDR_W-1:0] w_paddr;
   logic              w_pre;
   logic              w_pr;
   logic [ADDR_W-1:0] w_ptgt;
   logic              w_be;
   logic [ADDR_W-1:0] w_baddr;
   logic              w_br;
   logic [ADDR_W-1:0] w_btgt;
   logic              w_flush;
   logic [31:0]       w_stat_upd;
   logic [31:0]       w_stat_mis;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];

   m_btb_predictor #(.ENTRIES(4), .ADDR_W(ADDR_W), .CNT_W(2)) dut (
      .w_clk      (w_clk),
      .w_rst      (w_rst),
      .w_paddr    (w_paddr),
      .w_pre      (w_pre),
      .w_pr       (w_pr),
      .w_ptgt     (w_ptgt),
      .w_be       (w_be),
      .w_baddr    (w_baddr),
      .w_br       (w_br),
      .w_btgt     (w_btgt),
      .w_flush    (w_flush),
      .w_stat_upd (w_stat_upd),
      .w_stat_mis (w_stat_mis)
   );

   // Clock
   always #5 w_clk = ~w_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic flush, input logic be,
                      input logic [ADDR_W-1:0] baddr, input logic br,
                      input logic [ADDR_W-1:0] btgt, input logic [ADDR_W-1:0] paddr,
                      input logic epre, input logic epr,
                      input logic [ADDR_W-1:0] eptgt, input string name);
      vec_t v;
      v.rst = rst; v.flush = flush; v.be = be; v.baddr = baddr; v.br = br;
      v.btgt = btgt; v.paddr = paddr; v.exp_pre = epre; v.exp_pr = epr;
      v.exp_ptgt = eptgt; v.name = name;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs, check the pre-edge lookup at negedge, then take the edge.
   task automatic apply(input vec_t v);
      w_rst   = v.rst;
      w_flush = v.flush;
      w_be    = v.be;
      w_baddr = v.baddr;
      w_br    = v.br;
      w_btgt  = v.btgt;
      w_paddr = v.paddr;
      @(negedge w_clk);
      check({v.name, ".pre"},  32'(w_pre),  32'(v.exp_pre));
      check({v.name, ".pr"},   32'(w_pr),   32'(v.exp_pr));
      check({v.name, ".ptgt"}, 32'(w_ptgt), 32'(v.exp_ptgt));
      @(posedge w_clk);
      #1;
   endtask

   initial begin
      w_rst = 1'b1; w_flush = 1'b0; w_be = 1'b0; w_baddr = '0; w_br = 1'b0;
      w_btgt = '0; w_paddr = 11'h010;
      @(posedge w_clk);
      #1;
      w_rst = 1'b0;
      @(negedge w_clk);
      check("reset.pre",  32'(w_pre),  32'd0);
      check("reset.pr",   32'(w_pr),   32'd0);
      check("reset.ptgt", 32'(w_ptgt), 32'd0);
      check("reset.stat_upd", w_stat_upd, 32'd0);
      check("reset.stat_mis", w_stat_mis, 32'd0);
      @(posedge w_clk);
      #1;

      //   rst flush be  baddr   br  btgt    paddr   pre pr  ptgt
      // Allocate and counter walk on 0x010
      add(0, 0, 1, 11'h010, 1, 11'h020, 11'h010, 0, 0, 11'h000, "alloc_nobypass");
      add(0, 0, 1, 11'h010, 0, 11'h7ff, 11'h010, 1, 1, 11'h020, "hit_wt");
      add(0, 0, 1, 11'h010, 0, 11'h7ff, 11'h010, 1, 0, 11'h020, "hit_wnt");
      add(0, 0, 1, 11'h010, 0, 11'h7ff, 11'h010, 1, 0, 11'h020, "hit_snt");
      add(0, 0, 1, 11'h010, 1, 11'h055, 11'h010, 1, 0, 11'h020, "sat_low");
      add(0, 0, 1, 11'h010, 1, 11'h066, 11'h010, 1, 0, 11'h055, "tgt_upd1");
      add(0, 0, 1, 11'h010, 1, 11'h066, 11'h010, 1, 1, 11'h066, "tgt_upd2");
      add(0, 0, 1, 11'h010, 1, 11'h066, 11'h010, 1, 1, 11'h066, "cnt_st");
      add(0, 0, 1, 11'h010, 0, 11'h000, 11'h010, 1, 1, 11'h066, "sat_high");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h010, 1, 1, 11'h066, "after_dec");
      // Flush against a same-cycle update
      add(0, 0, 1, 11'h001, 1, 11'h101, 11'h001, 0, 0, 11'h000, "alloc_01");
      add(0, 0, 1, 11'h002, 0, 11'h102, 11'h001, 1, 1, 11'h101, "alloc_02");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h002, 1, 0, 11'h102, "look_02");
      add(0, 1, 1, 11'h007, 1, 11'h077, 11'h002, 1, 0, 11'h102, "flush_be");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h001, 0, 0, 11'h000, "fl_01");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h002, 0, 0, 11'h000, "fl_02");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h007, 0, 0, 11'h000, "fl_07");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h010, 0, 0, 11'h000, "fl_010");
      add(0, 0, 1, 11'h008, 0, 11'h088, 11'h008, 0, 0, 11'h000, "alloc_08");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h008, 1, 0, 11'h088, "look_08");
      // Mid-operation reset with a same-cycle update
      add(1, 0, 1, 11'h00f, 1, 11'h0ff, 11'h008, 1, 0, 11'h088, "rst_be");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h00f, 0, 0, 11'h000, "rst_0f");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h008, 0, 0, 11'h000, "rst_08");
      // LRU eviction
      add(0, 0, 1, 11'h001, 1, 11'h101, 11'h000, 0, 0, 11'h000, "lru_a1");
      add(0, 0, 1, 11'h002, 1, 11'h102, 11'h000, 0, 0, 11'h000, "lru_a2");
      add(0, 0, 1, 11'h003, 1, 11'h103, 11'h000, 0, 0, 11'h000, "lru_a3");
      add(0, 0, 1, 11'h004, 0, 11'h104, 11'h000, 0, 0, 11'h000, "lru_a4");
      add(0, 0, 1, 11'h001, 1, 11'h111, 11'h000, 0, 0, 11'h000, "lru_h1");
      add(0, 0, 1, 11'h005, 1, 11'h105, 11'h000, 0, 0, 11'h000, "lru_a5");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h002, 0, 0, 11'h000, "lru_ev2");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h001, 1, 1, 11'h111, "lru_k1");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h003, 1, 1, 11'h103, "lru_k3");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h004, 1, 0, 11'h104, "lru_k4");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h005, 1, 1, 11'h105, "lru_k5");
      add(0, 0, 1, 11'h006, 1, 11'h106, 11'h006, 0, 0, 11'h000, "lru_a6");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h003, 0, 0, 11'h000, "lru_ev3");
      add(0, 0, 1, 11'h009, 0, 11'h109, 11'h006, 1, 1, 11'h106, "lru_a9");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h004, 0, 0, 11'h000, "lru_ev4");
      // Same-cycle update and lookup of the same PC (miss)
      add(0, 0, 1, 11'h030, 1, 11'h031, 11'h030, 0, 0, 11'h000, "same_cyc");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h030, 1, 1, 11'h031, "same_next");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h001, 0, 0, 11'h000, "lru_ev1");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h005, 1, 1, 11'h105, "lru_k5b");

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
      end
      vecs.delete();

      // Statistics: reset (with a dropped update), then miss, correct hit, wrong-direction hit
      add(1, 0, 1, 11'h050, 1, 11'h051, 11'h030, 1, 1, 11'h031, "st_rst");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h050, 0, 0, 11'h000, "st_50");
      add(0, 0, 1, 11'h040, 1, 11'h041, 11'h040, 0, 0, 11'h000, "st_miss");
      add(0, 0, 1, 11'h040, 1, 11'h041, 11'h040, 1, 1, 11'h041, "st_hit_ok");
      add(0, 0, 1, 11'h040, 0, 11'h000, 11'h040, 1, 1, 11'h041, "st_hit_dir");
      for (int i = 0; i < 2; i++) begin
         apply(vecs[i]);
      end
      check("stat_upd_after_rst", w_stat_upd, 32'd0);
      check("stat_mis_after_rst", w_stat_mis, 32'd0);
      for (int i = 2; i < vecs.size(); i++) begin
         apply(vecs[i]);
      end
      check("stat_upd", w_stat_upd, 32'(EXP_UPD));
      check("stat_mis", w_stat_mis, 32'(EXP_MIS));
      vecs.delete();

      add(1, 0, 0, 11'h000, 0, 11'h000, 11'h040, 1, 1, 11'h041, "st_rst2");
      add(0, 0, 0, 11'h000, 0, 11'h000, 11'h040, 0, 0, 11'h000, "st_40_gone");
      apply(vecs[0]);
      check("stat_upd_rst2", w_stat_upd, 32'd0);
      check("stat_mis_rst2", w_stat_mis, 32'd0);
      apply(vecs[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
